// File: rtl/he_feeder_pkg.sv
// Shared state, product-index types and operand mapping for the tile feeder.
// Build option: POLY_MUL_FEEDER_TIMEOUT_EN enables the drain watchdog in the top.
`ifndef DEGREE_N
`define DEGREE_N 8
`endif
`ifndef TILE_N
`define TILE_N 4
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

package he_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CLEAR,
    FINISH
  } feeder_state_t;

  typedef logic [1:0] prod_idx_t;

  // Bit p selects the ciphertext component used by product p:
  // a1*b1, a0*b1, a1*b0, a0*b0.
  localparam logic [3:0] A_IDX_MAP = 4'b0101;
  localparam logic [3:0] B_IDX_MAP = 4'b0011;

  function automatic logic a_sel(input prod_idx_t p);
    return A_IDX_MAP[p];
  endfunction

  function automatic logic b_sel(input prod_idx_t p);
    return B_IDX_MAP[p];
  endfunction

endpackage

// File: rtl/tile_pair_counter.sv
// Nested (ta, tb) tile counter: tb is the minor index, ta advances when tb wraps.
// last_o flags the final pair (NT-1, NT-1) of a product.
module tile_pair_counter #(
  parameter int NT = 2,
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] ta_o,
  output logic [CW-1:0] tb_o,
  output logic          last_o
);

  localparam logic [CW-1:0] LAST = CW'(NT - 1);

  logic [CW-1:0] ta_reg;
  logic [CW-1:0] tb_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ta_reg <= '0;
      tb_reg <= '0;
    end else if (clr) begin
      ta_reg <= '0;
      tb_reg <= '0;
    end else if (adv) begin
      if (tb_reg == LAST) begin
        tb_reg <= '0;
        ta_reg <= (ta_reg == LAST) ? '0 : ta_reg + 1'b1;
      end else begin
        tb_reg <= tb_reg + 1'b1;
      end
    end
  end

  assign ta_o   = ta_reg;
  assign tb_o   = tb_reg;
  assign last_o = (ta_reg == LAST) && (tb_reg == LAST);

endmodule

// File: rtl/poly_mul_tile_feeder.sv
// Streams the four tensor-product tile pairs of two captured ciphertexts into the
// poly-mul wrapper. Build option: POLY_MUL_FEEDER_TIMEOUT_EN adds a drain watchdog.
`ifndef DEGREE_N
`define DEGREE_N 8
`endif
`ifndef TILE_N
`define TILE_N 4
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

module poly_mul_tile_feeder
  import he_feeder_pkg::*;
#(
  parameter int DEGREE_N       = `DEGREE_N,
  parameter int TILE_N         = `TILE_N,
  parameter int BIT_WIDTH      = `BIT_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start_i,
  input  logic [1:0][DEGREE_N-1:0][BIT_WIDTH-1:0] ct_a_i,
  input  logic [1:0][DEGREE_N-1:0][BIT_WIDTH-1:0] ct_b_i,
  output logic [TILE_N-1:0][BIT_WIDTH-1:0]        as_o,
  output logic [TILE_N-1:0][BIT_WIDTH-1:0]        bs_o,
  output logic                                    start_o,
  input  logic                                    ready_i,
  input  logic                                    poly_mul_done_i,
  output logic                                    rst_poly_mul_o,
  output prod_idx_t                               prod_idx_o,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    err_o
);

  localparam int NT = DEGREE_N / TILE_N;
  localparam int CW = (NT > 1) ? $clog2(NT) : 1;
  localparam int IW = (DEGREE_N > 1) ? $clog2(DEGREE_N) : 1;

  feeder_state_t state_reg;
  prod_idx_t     prod_reg;
  logic          start_reg;
  logic          rst_pm_reg;
  logic          done_reg;
  logic          err_reg;
  logic          abort_reg;
  logic          wd_hit;

  logic [1:0][DEGREE_N-1:0][BIT_WIDTH-1:0] ca_reg;
  logic [1:0][DEGREE_N-1:0][BIT_WIDTH-1:0] cb_reg;

  logic [CW-1:0] ta;
  logic [CW-1:0] tb;
  logic          last_pair;
  logic          xfer;
  logic          cnt_clr;

  assign xfer    = start_reg && ready_i;
  assign cnt_clr = (state_reg == IDLE) || (state_reg == CLEAR);

  tile_pair_counter #(
    .NT(NT),
    .CW(CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .adv   (xfer),
    .ta_o  (ta),
    .tb_o  (tb),
    .last_o(last_pair)
  );

  // Operands are only written on an accepted start, so they cannot move mid-run.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && start_i) begin
      ca_reg <= ct_a_i;
      cb_reg <= ct_b_i;
    end
  end

`ifdef POLY_MUL_FEEDER_TIMEOUT_EN
  logic [31:0] wd_reg;

  assign wd_hit = (state_reg == DRAIN) && (wd_reg == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_reg <= '0;
    end else if (state_reg == DRAIN && !poly_mul_done_i && !wd_hit) begin
      wd_reg <= wd_reg + 32'd1;
    end else begin
      wd_reg <= '0;
    end
  end
`else
  logic timeout_unused;

  assign timeout_unused = |TIMEOUT_CYCLES;
  assign wd_hit         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      prod_reg   <= '0;
      start_reg  <= 1'b0;
      rst_pm_reg <= 1'b1;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      abort_reg  <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      rst_pm_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            prod_reg  <= '0;
            err_reg   <= 1'b0;
            abort_reg <= 1'b0;
            start_reg <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (xfer && last_pair) begin
            start_reg <= 1'b0;
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (poly_mul_done_i) begin
            rst_pm_reg <= 1'b0;
            state_reg  <= CLEAR;
          end else if (wd_hit) begin
            rst_pm_reg <= 1'b0;
            err_reg    <= 1'b1;
            abort_reg  <= 1'b1;
            state_reg  <= CLEAR;
          end
        end
        CLEAR: begin
          if (abort_reg) begin
            state_reg <= IDLE;
          end else if (prod_reg == 2'd3) begin
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end else begin
            prod_reg  <= prod_reg + 2'd1;
            start_reg <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        FINISH: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic a_idx;
  logic b_idx;
  assign a_idx = a_sel(prod_reg);
  assign b_idx = b_sel(prod_reg);

  for (genvar gi = 0; gi < TILE_N; gi++) begin : g_lane
    logic [IW-1:0] a_pos;
    logic [IW-1:0] b_pos;
    assign a_pos    = IW'(int'(ta) * TILE_N + gi);
    assign b_pos    = IW'(int'(tb) * TILE_N + gi);
    assign as_o[gi] = start_reg ? ca_reg[a_idx][a_pos] : '0;
    assign bs_o[gi] = start_reg ? cb_reg[b_idx][b_pos] : '0;
  end

  assign start_o        = start_reg;
  assign rst_poly_mul_o = rst_pm_reg;
  assign prod_idx_o     = prod_reg;
  assign busy_o         = (state_reg != IDLE);
  assign done_o         = done_reg;
  assign err_o          = err_reg;

endmodule

// File: tb/tb_poly_mul_tile_feeder.sv
// Randomized bench for poly_mul_tile_feeder: a queue of expected tile pairs built
// from the product order plus a cycle-level wrapper model for drain/clear/done.
module tb_poly_mul_tile_feeder;

  localparam int DN = 8;
  localparam int TN = 4;
  localparam int BW = 16;
  localparam int NT = DN / TN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0;
  logic ready_i = 1'b0;
  logic poly_mul_done_i = 1'b0;
  logic [1:0][DN-1:0][BW-1:0] ct_a_i = '0;
  logic [1:0][DN-1:0][BW-1:0] ct_b_i = '0;
  logic [TN-1:0][BW-1:0] as_o;
  logic [TN-1:0][BW-1:0] bs_o;
  logic start_o, rst_poly_mul_o, busy_o, done_o, err_o;
  logic [1:0] prod_idx_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  poly_mul_tile_feeder #(
    .DEGREE_N(DN),
    .TILE_N(TN),
    .BIT_WIDTH(BW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .ct_a_i         (ct_a_i),
    .ct_b_i         (ct_b_i),
    .as_o           (as_o),
    .bs_o           (bs_o),
    .start_o        (start_o),
    .ready_i        (ready_i),
    .poly_mul_done_i(poly_mul_done_i),
    .rst_poly_mul_o (rst_poly_mul_o),
    .prod_idx_o     (prod_idx_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  typedef struct {
    logic [1:0]  prod;
    logic [63:0] a;
    logic [63:0] b;
  } xfer_t;

  typedef enum int {P_IDLE, P_ISSUE, P_DRAIN, P_CLEAR, P_FIN} phase_t;

  xfer_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] tile_of(input logic [DN-1:0][BW-1:0] poly, input int t);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < TN; k++) r[k*BW +: BW] = poly[t*TN + k];
    return r;
  endfunction

  function automatic logic pick_ready(input int mode, input int k);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[k % 4];
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic rand_ct(output logic [1:0][DN-1:0][BW-1:0] ct);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DN; j++) ct[i][j] = 16'($urandom);
  endtask

  // Product order a1*b1, a0*b1, a1*b0, a0*b0; tiles ta-major, tb-minor.
  task automatic build_expected(input logic [1:0][DN-1:0][BW-1:0] ca,
                                input logic [1:0][DN-1:0][BW-1:0] cb);
    int ai, bi;
    xfer_t x;
    exp_q.delete();
    for (int p = 0; p < 4; p++) begin
      ai = (p == 0 || p == 2) ? 1 : 0;
      bi = (p < 2) ? 1 : 0;
      for (int ta = 0; ta < NT; ta++)
        for (int tb = 0; tb < NT; tb++) begin
          x.prod = 2'(p);
          x.a = tile_of(ca[ai], ta);
          x.b = tile_of(cb[bi], tb);
          exp_q.push_back(x);
        end
    end
  endtask

  task automatic run_one(input int mode, input bit spur, input bit hold,
                         input bit mutate, input bit rst_mid);
    logic [1:0][DN-1:0][BW-1:0] ca, cb, junk;
    phase_t ph, nph;
    int eprod, cnt, dly, k, cyc, n_done;
    bit started, finished, spur_done, aborted, xf;
    xfer_t x;

    rand_ct(ca);
    rand_ct(cb);
    build_expected(ca, cb);
    @(posedge clk); #1;
    ct_a_i = ca; ct_b_i = cb; start_i = 1'b1;
    poly_mul_done_i = 1'b0;
    k = 0;
    ready_i = pick_ready(mode, k);
    ph = P_IDLE; eprod = 0; cnt = 0; dly = 0; cyc = 0; n_done = 0;
    started = 0; finished = 0; spur_done = 0; aborted = 0;

    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      check("start_o", start_o, ph == P_ISSUE);
      check("rst_poly_mul_o", rst_poly_mul_o, ph != P_CLEAR);
      check("done_o", done_o, ph == P_FIN);
      check("busy_o", busy_o, ph != P_IDLE);
      check("err_o", err_o, 1'b0);
      if (done_o) n_done++;
      if (ph == P_ISSUE || ph == P_DRAIN || ph == P_CLEAR)
        check("prod_idx_o", prod_idx_o, eprod);
      xf = (ph == P_ISSUE) && ready_i;
      if (ph == P_ISSUE && exp_q.size() > 0) begin
        check("as_o", as_o, exp_q[0].a);
        check("bs_o", bs_o, exp_q[0].b);
      end
      if (xf) begin
        if (exp_q.size() == 0) begin
          check("extra_transfer", 1, 0);
        end else begin
          x = exp_q.pop_front();
          $display("xfer prod=%0d as=%h bs=%h", x.prod, as_o, bs_o);
        end
        cnt++;
      end

      if (rst_mid && ph == P_DRAIN && eprod == 2) begin
        #2 rst = 1'b0;
        #1;
        check("rst_start_o", start_o, 1'b0);
        check("rst_rst_poly_mul_o", rst_poly_mul_o, 1'b1);
        check("rst_prod_idx_o", prod_idx_o, 2'd0);
        check("rst_busy_o", busy_o, 1'b0);
        check("rst_done_o", done_o, 1'b0);
        check("rst_err_o", err_o, 1'b0);
        check("rst_as_o", as_o, 64'd0);
        check("rst_bs_o", bs_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; start_i = 1'b0; poly_mul_done_i = 1'b0;
        aborted = 1;
        break;
      end

      nph = ph;
      case (ph)
        P_IDLE: begin
          if (!started) begin nph = P_ISSUE; started = 1; end
          else finished = 1;
        end
        P_ISSUE: if (xf && cnt == NT*NT) begin
          nph = P_DRAIN; cnt = 0;
          dly = (mode == 0) ? 2 : $urandom_range(0, 3);
        end
        P_DRAIN: if (poly_mul_done_i) nph = P_CLEAR;
        P_CLEAR: begin
          if (eprod == 3) nph = P_FIN;
          else begin eprod++; nph = P_ISSUE; end
        end
        P_FIN: nph = P_IDLE;
        default: nph = P_IDLE;
      endcase
      if (finished) break;

      @(posedge clk); #1;
      k++;
      start_i = hold && (nph == P_ISSUE || nph == P_DRAIN || nph == P_CLEAR);
      if (mutate && k == 1) begin
        rand_ct(junk); ct_a_i = junk;
        rand_ct(junk); ct_b_i = junk;
      end
      ready_i = pick_ready(mode, k);
      poly_mul_done_i = 1'b0;
      if (nph == P_DRAIN) begin
        if (dly == 0) poly_mul_done_i = 1'b1;
        else dly--;
      end
      if (spur && !spur_done && nph == P_ISSUE && eprod == 1 && cnt == 1) begin
        poly_mul_done_i = 1'b1;
        spur_done = 1;
      end
      ph = nph;
    end

    start_i = 1'b0;
    if (!aborted) begin
      check("run_finished", finished, 1'b1);
      check("queue_empty", exp_q.size(), 0);
      check("done_pulses", n_done, 1);
    end
  endtask

`ifdef POLY_MUL_FEEDER_TIMEOUT_EN
  task automatic run_timeout();
    logic [1:0][DN-1:0][BW-1:0] ca;
    int nx, ndrain, n_done;
    bit hit;
    rand_ct(ca);
    @(posedge clk); #1;
    ct_a_i = ca; start_i = 1'b1; ready_i = 1'b1; poly_mul_done_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    nx = 0; ndrain = 0; n_done = 0; hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (done_o) n_done++;
      if (!rst_poly_mul_o) hit = 1;
      else if (nx == NT*NT) ndrain++;
      if (start_o && ready_i) nx++;
    end
    check("wd_fired", hit, 1'b1);
    check("wd_err_o", err_o, 1'b1);
    check("wd_drain_cycles", ndrain, 16);
    @(negedge clk);
    check("wd_rst_release", rst_poly_mul_o, 1'b1);
    check("wd_idle", busy_o, 1'b0);
    check("wd_no_done", done_o | (n_done != 0), 1'b0);
    check("wd_err_sticky", err_o, 1'b1);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("wd_err_cleared", err_o, 1'b0);
    for (int c = 0; c < 200 && busy_o; c++) @(negedge clk);
    check("wd_second_idle", busy_o, 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_start_o", start_o, 1'b0);
    check("reset_rst_poly_mul_o", rst_poly_mul_o, 1'b1);
    check("reset_prod_idx_o", prod_idx_o, 2'd0);
    check("reset_busy_o", busy_o, 1'b0);
    check("reset_done_o", done_o, 1'b0);
    check("reset_err_o", err_o, 1'b0);
    check("reset_as_o", as_o, 64'd0);
    check("reset_bs_o", bs_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_one(0, 0, 0, 0, 0);
    run_one(1, 0, 0, 0, 0);
    run_one(0, 1, 0, 0, 0);
    run_one(2, 0, 1, 1, 0);
    run_one(0, 0, 0, 0, 1);
    run_one(2, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) run_one(2, r[0], r[1], r[1], 0);
`ifdef POLY_MUL_FEEDER_TIMEOUT_EN
    run_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_mul_tile_feeder.md
# poly_mul_tile_feeder

Upstream operand scheduler for the polynomial-multiply/relinearisation wrapper. Captures two degree-2-free ciphertexts A=(a0,a1) and B=(b0,b1) and streams `TILE_N`-wide coefficient tile pairs into the wrapper's `as`/`bs` inputs. It issues the four tensor products in the wrapper's consumption order, a1·b1, a0·b1, a1·b0 and then a0·b0. Between products it clears the multiplier through `rst_poly_mul`.

## Interface
- `DEGREE_N`, default `` `DEGREE_N ``: coefficients per polynomial.
- `TILE_N`, default `` `TILE_N ``: coefficients per tile. Must divide `DEGREE_N`. NT = `DEGREE_N`/`TILE_N`.
- `BIT_WIDTH`, default `` `BIT_WIDTH ``: coefficient width.
- `TIMEOUT_CYCLES`, default 4096: drain watchdog limit. Used only under `POLY_MUL_FEEDER_TIMEOUT_EN`.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: capture operands and begin. Accepted only in IDLE.
- `ct_a_i`, in, [1:0][DEGREE_N-1:0][BIT_WIDTH-1:0]: ciphertext A. Index 0 is a0, index 1 is a1.
- `ct_b_i`, in, [1:0][DEGREE_N-1:0][BIT_WIDTH-1:0]: ciphertext B.
- `as_o`, out, [TILE_N-1:0][BIT_WIDTH-1:0]: A tile to the wrapper.
- `bs_o`, out, [TILE_N-1:0][BIT_WIDTH-1:0]: B tile to the wrapper.
- `start_o`, out, 1: tile pair valid. Drives the wrapper's `start`.
- `ready_i`, in, 1: wrapper `ready_o` (multiplier ready for a tile).
- `poly_mul_done_i`, in, 1: wrapper `poly_mul_done`.
- `rst_poly_mul_o`, out, 1: active-low multiplier clear.
- `prod_idx_o`, out, 2: current product. 0 = a1·b1, 1 = a0·b1, 2 = a1·b0, 3 = a0·b0.
- `busy_o`, out, 1: high in every state except IDLE.
- `done_o`, out, 1: one-cycle pulse after the last product has drained.
- `err_o`, out, 1: sticky watchdog error, cleared by `start_i`. Tied to 0 without the macro.

## Operation
- Reset values: state IDLE, `start_o`=0, `rst_poly_mul_o`=1, `prod_idx_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, tile counters 0, `as_o`/`bs_o`=0.
- State machine:
  - IDLE: on `start_i`, latch `ct_a_i`/`ct_b_i` into capture registers, set prod=0, ta=tb=0, and go to ISSUE.
  - ISSUE: `start_o`=1. `as_o` = A_sel[ta·TILE_N +: TILE_N] and `bs_o` = B_sel[tb·TILE_N +: TILE_N], where A_sel/B_sel come from the prod mapping.
    - A transfer occurs on a cycle with `start_o` & `ready_i`. On a transfer, tb increments; when tb wraps from NT-1 to 0, ta increments.
    - The transfer of pair (NT-1, NT-1) moves to DRAIN.
  - DRAIN: `start_o`=0. Wait for `poly_mul_done_i`, then go to CLEAR.
  - CLEAR: `rst_poly_mul_o`=0 for exactly one cycle. If prod=3, go to FINISH. Otherwise prod+1, ta=tb=0, back to ISSUE.
  - FINISH: `done_o`=1 for one cycle, then IDLE.
- Each product issues exactly NT² pairs in ta-major, tb-minor order. A full run is 4·NT² transfers.
- With `ready_i` low, `start_o`, `as_o` and `bs_o` hold stable. Counters do not move.
- `poly_mul_done_i` outside DRAIN is ignored.
- `start_i` outside IDLE is ignored. The captured operands never change mid-run.
- Asynchronous `rst` low mid-run forces all reset values immediately. No partial `done_o` is produced.
- Counters are `$clog2(NT)` bits wide, or 1 bit when NT=1. The NT=1 case moves ISSUE to DRAIN after a single transfer.

## Timing
- `start_i` sampled in cycle T gives `start_o`=1 in T+1 with tile pair (0,0).
- Back-to-back transfers are possible every cycle while `ready_i`=1.
- `poly_mul_done_i` in cycle D gives `rst_poly_mul_o`=0 in D+1. The next product's `start_o` is in D+2, or `done_o` is in D+2 after the last product.
- `as_o`/`bs_o` are a combinational mux from the capture registers, state and counters. There is no path from `ready_i` to `start_o`.

## Configuration
- `POLY_MUL_FEEDER_TIMEOUT_EN` defined:
  - A counter runs in DRAIN. It reaches `TIMEOUT_CYCLES` if `poly_mul_done_i` is absent for that many cycles.
  - When it does, `err_o` is set and the block goes through CLEAR straight to IDLE, with no `done_o`.
- Undefined: no counter, DRAIN waits indefinitely, `err_o` is constant 0.

## Structure
- Shared package `he_feeder_pkg` holds:
  - the state enum (IDLE, ISSUE, DRAIN, CLEAR, FINISH);
  - the `prod_idx_t` typedef;
  - the product-to-operand mapping constants, A index = {1,0,1,0} and B index = {1,1,0,0}.
- One sub-module, `tile_pair_counter`: nested ta/tb counter with an advance input, synchronous clear and a `last_o` flag at (NT-1, NT-1).

## Test plan
- Full run, DEGREE_N=8, TILE_N=4, `ready_i`=1, done returned 3 cycles after the last transfer:
  - 16 transfers in order (prod, ta, tb) = (0,0,0) … (3,1,1);
  - `as_o` for prod 0 is a1[3:0], a1[3:0], a1[7:4], a1[7:4];
  - `done_o` pulses exactly once.
- `ready_i` toggled 1,0,0,1: `start_o` and tile data held over the stalled cycles, no pair skipped or duplicated.
- `poly_mul_done_i` pulsed during ISSUE of prod 1: ignored. Transfer count for prod 1 is still 4.
- `rst` dropped asynchronously during DRAIN of prod 2: all outputs return to reset values at once. A new `start_i` restarts at prod 0.
- `start_i` held high through the whole run: no recapture, and `ct_a_i` changed mid-run does not affect `as_o`.
- With `POLY_MUL_FEEDER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, withhold done: `err_o`=1, `rst_poly_mul_o` low for one cycle, return to IDLE, no `done_o`. The next `start_i` clears `err_o`.
